dm_phase_ctrl: RTL and testbench

Sequencer for the shared data-memory selector. Drives the 2-bit `status` select through three phases: host load (com writes DM), processor run (cores own DM), and host dump (com reads DM). Counts load words, launches the cores, waits for every core to report done (with a watchdog), then walks the dump address range for the communication block. Sits between the communication block, the processor cores and the DM selector.

---
 rtl/dm_phase_ctrl.sv | 140 ++++++++++++++
 tb/tb_dm_phase_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dm_phase_ctrl.sv
// dm_phase_ctrl: sequences the shared data-memory selector through host load,
// processor run and host dump phases.
`default_nettype none

module dm_phase_ctrl #(
  parameter int          NUM_CORES   = 4,
  parameter int          LOAD_WORDS  = 256,
  parameter logic [15:0] DUMP_BASE   = 16'h0000,
  parameter int          DUMP_WORDS  = 256,
  parameter int          RUN_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 com_wr_en,
  input  logic                 com_rd_ack,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [1:0]           status,
  output logic                 load_ready,
  output logic [15:0]          load_count,
  output logic                 core_start,
  output logic [15:0]          dump_addr,
  output logic                 dump_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam logic [15:0] LOAD_LAST = 16'(LOAD_WORDS - 1);
  localparam logic [15:0] DUMP_LAST = 16'(DUMP_WORDS - 1);
  localparam logic [15:0] WD_LAST   = 16'(RUN_TIMEOUT - 1);

  localparam logic [1:0] SEL_COM_WR = 2'b00;
  localparam logic [1:0] SEL_PROC   = 2'b01;
  localparam logic [1:0] SEL_COM_RD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LAUNCH = 3'd2,
    RUN    = 3'd3,
    DUMP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t               state;
  logic [NUM_CORES-1:0] done_lat;
  logic [NUM_CORES-1:0] done_now;
  logic                 all_done;
  logic [15:0]          wd_cnt;
  logic [15:0]          dump_cnt;

  // Completion includes bits arriving this cycle, so a late done still wins over the watchdog.
  assign done_now = done_lat | core_done;
  assign all_done = &done_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      status      <= SEL_COM_WR;
      load_ready  <= 1'b0;
      load_count  <= 16'd0;
      core_start  <= 1'b0;
      dump_addr   <= DUMP_BASE;
      dump_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      done_lat    <= '0;
      wd_cnt      <= 16'd0;
      dump_cnt    <= 16'd0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= LOAD;
            status      <= SEL_COM_WR;
            load_ready  <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            load_count  <= 16'd0;
            done_lat    <= '0;
            wd_cnt      <= 16'd0;
            timeout_err <= 1'b0;
          end
        end
        LOAD: begin
          if (com_wr_en) begin
            load_count <= load_count + 16'd1;
            if (load_count == LOAD_LAST) begin
              state      <= LAUNCH;
              status     <= SEL_PROC;
              load_ready <= 1'b0;
              core_start <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state <= RUN;
        end
        RUN: begin
          done_lat <= done_now;
          wd_cnt   <= wd_cnt + 16'd1;
          if (all_done || (wd_cnt == WD_LAST)) begin
            state       <= DUMP;
            status      <= SEL_COM_RD;
            dump_valid  <= 1'b1;
            dump_addr   <= DUMP_BASE;
            dump_cnt    <= 16'd0;
            timeout_err <= ~all_done;
          end
        end
        DUMP: begin
          if (com_rd_ack) begin
            dump_addr <= dump_addr + 16'd1;
            dump_cnt  <= dump_cnt + 16'd1;
            if (dump_cnt == DUMP_LAST) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          status     <= SEL_COM_WR;
          load_ready <= 1'b0;
          dump_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_phase_ctrl.sv
// tb_dm_phase_ctrl: directed-vector bench for dm_phase_ctrl with hand-computed expectations.
`default_nettype none

module tb_dm_phase_ctrl;

  logic clk = 1'b0;
  logic rst;

  // Instance a: nominal / watchdog / reset scenarios
  logic        start, com_wr_en, com_rd_ack;
  logic [1:0]  core_done;
  logic [1:0]  status;
  logic        load_ready, core_start, dump_valid, busy, done, timeout_err;
  logic [15:0] load_count, dump_addr;

  // Instance b: address wrap scenario
  logic        start_b, com_wr_en_b, com_rd_ack_b;
  logic [0:0]  core_done_b;
  logic [1:0]  status_b;
  logic        load_ready_b, core_start_b, dump_valid_b, busy_b, done_b, timeout_err_b;
  logic [15:0] load_count_b, dump_addr_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dm_phase_ctrl #(
    .NUM_CORES(2), .LOAD_WORDS(4), .DUMP_BASE(16'h0010), .DUMP_WORDS(3), .RUN_TIMEOUT(20)
  ) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .com_wr_en(com_wr_en), .com_rd_ack(com_rd_ack),
    .core_done(core_done), .status(status), .load_ready(load_ready), .load_count(load_count),
    .core_start(core_start), .dump_addr(dump_addr), .dump_valid(dump_valid), .busy(busy),
    .done(done), .timeout_err(timeout_err)
  );

  dm_phase_ctrl #(
    .NUM_CORES(1), .LOAD_WORDS(2), .DUMP_BASE(16'hFFFE), .DUMP_WORDS(4), .RUN_TIMEOUT(100)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .com_wr_en(com_wr_en_b), .com_rd_ack(com_rd_ack_b),
    .core_done(core_done_b), .status(status_b), .load_ready(load_ready_b),
    .load_count(load_count_b), .core_start(core_start_b), .dump_addr(dump_addr_b),
    .dump_valid(dump_valid_b), .busy(busy_b), .done(done_b), .timeout_err(timeout_err_b)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n);
    com_wr_en = 1'b1;
    for (int i = 0; i < n; i++) tick();
    com_wr_en = 1'b0;
  endtask

  task automatic ack_n(input int n);
    com_rd_ack = 1'b1;
    for (int i = 0; i < n; i++) tick();
    com_rd_ack = 1'b0;
  endtask

  logic [15:0] wrap_exp [4];

  initial begin
    rst = 1'b1; start = 1'b0; com_wr_en = 1'b0; com_rd_ack = 1'b0; core_done = 2'b00;
    start_b = 1'b0; com_wr_en_b = 1'b0; com_rd_ack_b = 1'b0; core_done_b = 1'b0;
    wrap_exp[0] = 16'hFFFF; wrap_exp[1] = 16'h0000; wrap_exp[2] = 16'h0001; wrap_exp[3] = 16'h0002;

    // Reset and idle
    tick(); tick();
    rst = 1'b0;
    check("rst_status", status, 2'b00);
    check("rst_dump_addr", dump_addr, 16'h0010);
    check("rst_flags", {load_ready, core_start, dump_valid, busy, done, timeout_err}, 6'b0);
    check("rst_dump_addr_b", dump_addr_b, 16'hFFFE);
    for (int i = 0; i < 10; i++) begin
      com_wr_en  = i[0];
      com_rd_ack = ~i[0];
      tick();
      check("idle_outputs",
            {status, load_ready, load_count, core_start, dump_addr, dump_valid, busy, done, timeout_err},
            {2'b00, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    com_wr_en = 1'b0; com_rd_ack = 1'b0;

    // Nominal flow with gapped writes; core 1 pulses during LOAD and must not be latched
    start = 1'b1; tick(); start = 1'b0;
    check("start_load_ready", {load_ready, busy, status}, {1'b1, 1'b1, 2'b00});
    for (int i = 0; i < 4; i++) begin
      com_wr_en = 1'b1; tick(); com_wr_en = 1'b0;
      if (i < 3) begin
        check("load_count_gapped", load_count, 16'(i + 1));
        if (i == 1) core_done = 2'b10;
        tick();
        core_done = 2'b00;
      end
    end
    check("launch_pulse", {core_start, status, load_ready, load_count}, {1'b1, 2'b01, 1'b0, 16'd4});
    tick();
    check("run_entry", {core_start, status}, {1'b0, 2'b01});
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) start = 1'b1;
      if (k == 5) core_done = 2'b01;
      if (k == 9) core_done = 2'b10;
      tick();
      start = 1'b0; core_done = 2'b00;
      if (k == 4) check("start_in_run_ignored", {status, busy, load_ready, load_count}, {2'b01, 1'b1, 1'b0, 16'd4});
      if (k == 5) check("load_pulse_not_latched", status, 2'b01);
      if (k == 8) check("run_waits_core1", status, 2'b01);
    end
    check("dump_entry", {status, dump_valid, dump_addr}, {2'b10, 1'b1, 16'h0010});
    for (int i = 0; i < 3; i++) begin
      com_rd_ack = 1'b1; tick();
      check("dump_addr_step", dump_addr, 16'(16'h0011 + i));
    end
    com_rd_ack = 1'b0;
    check("nominal_done", {status, done, dump_valid, busy, timeout_err}, {2'b10, 1'b1, 1'b0, 1'b0, 1'b0});

    // Watchdog: only core 0 reports
    start = 1'b1; tick(); start = 1'b0;
    write_n(4);
    check("wd_load_count", load_count, 16'd4);
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) core_done = 2'b01;
      tick();
      core_done = 2'b00;
      if (k == 19) check("wd_still_run", status, 2'b01);
    end
    check("wd_expired", {status, dump_valid, timeout_err}, {2'b10, 1'b1, 1'b1});
    ack_n(3);
    check("wd_done_sticky", {done, timeout_err}, {1'b1, 1'b1});
    start = 1'b1; tick(); start = 1'b0;
    check("wd_start_clears", {timeout_err, status, load_ready, load_count}, {1'b0, 2'b00, 1'b1, 16'd0});

    // Completion on the watchdog-expiry cycle
    write_n(4);
    tick();
    for (int k = 1; k <= 20; k++) begin
      if (k == 3)  core_done = 2'b01;
      if (k == 20) core_done = 2'b10;
      tick();
      core_done = 2'b00;
      if (k == 19) check("sim_still_run", status, 2'b01);
    end
    check("sim_completion_wins", {status, dump_valid, timeout_err}, {2'b10, 1'b1, 1'b0});
    ack_n(3);
    check("sim_done", {done, timeout_err, dump_addr}, {1'b1, 1'b0, 16'h0013});

    // Mid-load reset
    start = 1'b1; tick(); start = 1'b0;
    write_n(2);
    check("mid_load_count", load_count, 16'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_idle", {status, busy, load_ready, load_count, done}, {2'b00, 1'b0, 1'b0, 16'd0, 1'b0});
    start = 1'b1; tick(); start = 1'b0;
    write_n(4);
    check("mid_rst_relaunch", {load_count, core_start, status}, {16'd4, 1'b1, 2'b01});

    // Address wrap on instance b
    start_b = 1'b1; tick(); start_b = 1'b0;
    com_wr_en_b = 1'b1; tick(); tick(); com_wr_en_b = 1'b0;
    check("wrap_launch", {core_start_b, status_b}, {1'b1, 2'b01});
    tick();
    core_done_b = 1'b1; tick(); core_done_b = 1'b0;
    check("wrap_dump_entry", {status_b, dump_valid_b, dump_addr_b}, {2'b10, 1'b1, 16'hFFFE});
    for (int i = 0; i < 4; i++) begin
      com_rd_ack_b = 1'b1; tick();
      check("wrap_addr", dump_addr_b, wrap_exp[i]);
    end
    com_rd_ack_b = 1'b0;
    check("wrap_done", {done_b, dump_valid_b, busy_b, timeout_err_b}, {1'b1, 1'b0, 1'b0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
